// File: rtl/acc_stack_unit.sv
// acc_stack_unit: accumulator / stack-pointer datapath with a single-outstanding push/pop sequencer.
// Define STACK_GUARD_EN to reject stack overflow/underflow and raise the sticky stack_ovf/stack_unf flags.
module acc_stack_unit #(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       IMM_W       = 8,
  parameter logic [DATA_W-1:0] SP_RESET    = 16'hFFFE,
  parameter int unsigned       SP_STEP     = 2,
  parameter logic [DATA_W-1:0] STACK_LIMIT = 16'hFF00
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [IMM_W-1:0]  IR,
  input  logic [DATA_W-1:0] MemData,
  input  logic [DATA_W-1:0] ALU,
  input  logic [DATA_W-1:0] MDR,
  input  logic [2:0]        AccSrc,
  input  logic              AccWrite,
  input  logic [1:0]        SpOp,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] AccOutput,
  output logic [DATA_W-1:0] SpOutput,
  output logic [DATA_W-1:0] SE,
  output logic [DATA_W-1:0] SELeft,
  output logic [DATA_W-1:0] ZE,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam int unsigned       EXT_W      = DATA_W - IMM_W;
  localparam logic [DATA_W-1:0] STEP       = DATA_W'(SP_STEP);
  localparam logic [DATA_W-1:0] PUSH_FLOOR = STACK_LIMIT + STEP;

  localparam logic [1:0] SP_PUSH = 2'b01;
  localparam logic [1:0] SP_POP  = 2'b10;
  localparam logic [1:0] SP_LOAD = 2'b11;

`ifdef STACK_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUSH = 2'd1,
    S_POP  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_sp;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rd;
  logic              r_wr;
  logic              r_busy;
  logic              r_done;
  logic              r_ovf;
  logic              r_unf;

  logic [DATA_W-1:0] w_acc_nxt;
  logic [DATA_W-1:0] w_sp_nxt;
  logic [DATA_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic              w_rd_nxt;
  logic              w_wr_nxt;
  logic              w_done_nxt;
  logic              w_ovf_nxt;
  logic              w_unf_nxt;

  logic [DATA_W-1:0] w_se;
  logic [DATA_W-1:0] w_ze;
  logic [DATA_W-1:0] w_acc_mux;
  logic              w_push_ok;
  logic              w_pop_ok;

  // Immediate forms built straight from IR
  assign w_se   = {{EXT_W{IR[IMM_W-1]}}, IR};
  assign w_ze   = {{EXT_W{1'b0}}, IR};
  assign SE     = w_se;
  assign SELeft = {w_se[DATA_W-2:0], 1'b0};
  assign ZE     = w_ze;

  // Guard checks collapse to constant-true when the guard is compiled out
  assign w_push_ok = !GUARD_EN || (r_sp >= PUSH_FLOOR);
  assign w_pop_ok  = !GUARD_EN || (r_sp < SP_RESET);

  always_comb begin : p_acc_mux
    w_acc_mux = r_acc;
    case (AccSrc)
      3'd0:    w_acc_mux = {IR, {EXT_W{1'b0}}};
      3'd1:    w_acc_mux = MDR;
      3'd2:    w_acc_mux = MemData;
      3'd3:    w_acc_mux = w_se;
      3'd4:    w_acc_mux = ALU;
      3'd5:    w_acc_mux = w_ze;
      3'd6:    w_acc_mux = {r_acc[DATA_W-1:IMM_W], IR};
      default: w_acc_mux = r_acc;
    endcase
  end

  always_ff @(posedge CLK) begin : p_state_reg
    if (!reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_sp    <= SP_RESET;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_sp    <= w_sp_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_rd    <= w_rd_nxt;
      r_wr    <= w_wr_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  always_comb begin : p_next_state
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (SpOp == SP_PUSH && w_push_ok) begin
          w_state_nxt = S_PUSH;
        end else if (SpOp == SP_POP && w_pop_ok) begin
          w_state_nxt = S_POP;
        end
      end
      S_PUSH, S_POP: begin
        if (mem_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A rejected push/pop still consumes the cycle, so AccWrite is dropped for it as well
  always_comb begin : p_outputs
    w_acc_nxt   = r_acc;
    w_sp_nxt    = r_sp;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rd_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    case (r_state)
      S_IDLE: begin
        case (SpOp)
          SP_PUSH: begin
            if (w_push_ok) begin
              w_wr_nxt    = 1'b1;
              w_addr_nxt  = r_sp - STEP;
              w_wdata_nxt = r_acc;
            end else begin
              w_ovf_nxt = 1'b1;
            end
          end
          SP_POP: begin
            if (w_pop_ok) begin
              w_rd_nxt   = 1'b1;
              w_addr_nxt = r_sp;
            end else begin
              w_unf_nxt = 1'b1;
            end
          end
          SP_LOAD: begin
            w_sp_nxt = ALU;
            if (AccWrite) begin
              w_acc_nxt = w_acc_mux;
            end
          end
          default: begin
            if (AccWrite) begin
              w_acc_nxt = w_acc_mux;
            end
          end
        endcase
      end
      S_PUSH: begin
        if (mem_ready) begin
          w_sp_nxt   = r_sp - STEP;
          w_done_nxt = 1'b1;
        end else begin
          w_wr_nxt = 1'b1;
        end
      end
      S_POP: begin
        if (mem_ready) begin
          w_acc_nxt  = MemData;
          w_sp_nxt   = r_sp + STEP;
          w_done_nxt = 1'b1;
        end else begin
          w_rd_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign AccOutput = r_acc;
  assign SpOutput  = r_sp;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_rd    = r_rd;
  assign mem_wr    = r_wr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign stack_ovf = r_ovf;
  assign stack_unf = r_unf;

endmodule

// File: tb/tb_acc_stack_unit.sv
// Scoreboarded random bench for acc_stack_unit: a driver queues expected memory requests and
// completions, a negedge monitor checks them as the DUT presents them.
module tb_acc_stack_unit;

`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        reset;
  logic [7:0]  IR;
  logic [15:0] MemData, ALU, MDR;
  logic [2:0]  AccSrc;
  logic        AccWrite;
  logic [1:0]  SpOp;
  logic        mem_ready;
  logic [15:0] AccOutput, SpOutput, SE, SELeft, ZE, mem_addr, mem_wdata;
  logic        mem_rd, mem_wr, busy, done, stack_ovf, stack_unf;

  acc_stack_unit dut (
    .CLK(CLK), .reset(reset), .IR(IR), .MemData(MemData), .ALU(ALU), .MDR(MDR),
    .AccSrc(AccSrc), .AccWrite(AccWrite), .SpOp(SpOp), .mem_ready(mem_ready),
    .AccOutput(AccOutput), .SpOutput(SpOutput), .SE(SE), .SELeft(SELeft), .ZE(ZE),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .busy(busy), .done(done), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          len;
  } req_t;

  typedef struct {
    logic [15:0] acc;
    logic [15:0] sp;
  } cmp_t;

  req_t q_req[$];
  cmp_t q_done[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_acc, m_sp;
  bit          m_ovf, m_unf;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic noise();
    IR      = 8'($urandom);
    MDR     = 16'($urandom);
    ALU     = 16'($urandom);
    MemData = 16'($urandom);
    AccSrc  = 3'($urandom);
  endtask

  // Reference: Acc source selection from the mux table in plain arithmetic
  function automatic logic [15:0] acc_model(input logic [2:0] src, input logic [7:0] ir,
                                            input logic [15:0] mdr, input logic [15:0] memd,
                                            input logic [15:0] alu, input logic [15:0] acc);
    logic [15:0] ir16;
    ir16 = 16'(ir);
    case (src)
      3'd0: return 16'(ir16 * 256);
      3'd1: return mdr;
      3'd2: return memd;
      3'd3: return (ir >= 8'd128) ? 16'(ir16 + 16'hFF00) : ir16;
      3'd4: return alu;
      3'd5: return ir16;
      3'd6: return 16'((acc / 256) * 256 + ir16);
      default: return acc;
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    m_acc = 16'h0000; m_sp = 16'hFFFE; m_ovf = 1'b0; m_unf = 1'b0;
    check({tag, "_acc"},   AccOutput, 16'h0000);
    check({tag, "_sp"},    SpOutput,  16'hFFFE);
    check({tag, "_busy"},  busy,      1'b0);
    check({tag, "_rdwr"},  {mem_rd, mem_wr, done}, 3'b000);
    check({tag, "_addr"},  mem_addr,  16'h0000);
    check({tag, "_wdata"}, mem_wdata, 16'h0000);
    check({tag, "_flags"}, {stack_ovf, stack_unf}, 2'b00);
  endtask

  task automatic acc_load(input logic [2:0] src, input logic [7:0] ir);
    noise();
    AccSrc = src; IR = ir; AccWrite = 1'b1; SpOp = 2'b00;
    m_acc = acc_model(src, ir, MDR, MemData, ALU, m_acc);
    tick();
    AccWrite = 1'b0;
    check("acc_load", AccOutput, m_acc);
    check("acc_load_sp", SpOutput, m_sp);
  endtask

  task automatic imm_check(input logic [7:0] ir);
    logic [15:0] se;
    IR = ir;
    se = acc_model(3'd3, ir, 16'h0, 16'h0, 16'h0, 16'h0);
    #1;
    check("imm_se", SE, se);
    check("imm_seleft", SELeft, 16'(se * 2));
    check("imm_ze", ZE, 16'(ir));
  endtask

  task automatic sp_load(input logic [15:0] alu, input bit accw);
    noise();
    ALU = alu; SpOp = 2'b11; AccWrite = accw;
    if (accw) m_acc = acc_model(AccSrc, IR, MDR, MemData, ALU, m_acc);
    m_sp = alu;
    tick();
    SpOp = 2'b00; AccWrite = 1'b0;
    check("sp_load_sp", SpOutput, m_sp);
    check("sp_load_acc", AccOutput, m_acc);
    check("sp_load_nodone", {busy, done}, 2'b00);
  endtask

  task automatic wait_busy(input int waits);
    repeat (waits) begin
      noise();
      SpOp = 2'($urandom); AccWrite = 1'($urandom); mem_ready = 1'b0;
      tick();
    end
    noise();
    SpOp = 2'($urandom); AccWrite = 1'($urandom);
  endtask

  task automatic do_push(input int waits, input bit accw);
    bit rej;
    rej = GUARD && (m_sp < 16'hFF02);
    noise();
    SpOp = 2'b01; AccWrite = rej ? 1'b0 : accw; mem_ready = 1'b0;
    if (rej) begin
      m_ovf = 1'b1;
      tick();
      SpOp = 2'b00;
      check("push_rej_busy", {busy, mem_wr, done}, 3'b000);
    end else begin
      q_req.push_back('{is_wr: 1'b1, addr: 16'(m_sp - 16'd2), wdata: m_acc, len: waits + 1});
      m_sp = 16'(m_sp - 16'd2);
      q_done.push_back('{acc: m_acc, sp: m_sp});
      tick();
      check("push_busy", busy, 1'b1);
      wait_busy(waits);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0; SpOp = 2'b00; AccWrite = 1'b0;
    end
    check("push_flags", {stack_ovf, stack_unf}, {m_ovf, m_unf});
  endtask

  task automatic do_pop(input int waits, input logic [15:0] data);
    bit rej;
    rej = GUARD && (m_sp >= 16'hFFFE);
    noise();
    SpOp = 2'b10; AccWrite = 1'b0; mem_ready = 1'b0;
    if (rej) begin
      m_unf = 1'b1;
      tick();
      SpOp = 2'b00;
      check("pop_rej_busy", {busy, mem_rd, done}, 3'b000);
      check("pop_rej_sp", SpOutput, m_sp);
    end else begin
      q_req.push_back('{is_wr: 1'b0, addr: m_sp, wdata: 16'h0, len: waits + 1});
      m_sp  = 16'(m_sp + 16'd2);
      m_acc = data;
      q_done.push_back('{acc: m_acc, sp: m_sp});
      tick();
      check("pop_busy", busy, 1'b1);
      wait_busy(waits);
      MemData = data; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0; SpOp = 2'b00; AccWrite = 1'b0;
    end
    check("pop_flags", {stack_ovf, stack_unf}, {m_ovf, m_unf});
  endtask

  // Monitor: checks each memory request when it starts and ends, and each done pulse
  initial begin : monitor
    bit   prev_req;
    bit   have_cur;
    int   cur_len;
    req_t cur;
    cmp_t exp_done;
    prev_req = 1'b0; have_cur = 1'b0; cur_len = 0;
    forever begin
      @(negedge CLK);
      if (!mon_en) begin
        prev_req = 1'b0; have_cur = 1'b0; cur_len = 0;
      end else begin
        if ((mem_wr || mem_rd) && !prev_req) begin
          if (q_req.size() == 0) begin
            n_tests++; n_fail++; have_cur = 1'b0;
            $display("FAIL unexpected_req: wr=%b rd=%b addr=%h with no request expected",
                     mem_wr, mem_rd, mem_addr);
          end else begin
            cur = q_req.pop_front();
            have_cur = 1'b1;
            check("req_kind", {mem_wr, mem_rd}, {cur.is_wr, !cur.is_wr});
            check("req_addr", mem_addr, cur.addr);
            if (cur.is_wr) check("req_wdata", mem_wdata, cur.wdata);
          end
          cur_len = 1;
        end else if (mem_wr || mem_rd) begin
          cur_len++;
        end else if (prev_req && have_cur) begin
          check("req_len", cur_len, cur.len);
          have_cur = 1'b0;
        end
        prev_req = mem_wr || mem_rd;
        if (done) begin
          if (q_done.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_done: acc=%h sp=%h with no completion expected",
                     AccOutput, SpOutput);
          end else begin
            exp_done = q_done.pop_front();
            check("done_acc", AccOutput, exp_done.acc);
            check("done_sp", SpOutput, exp_done.sp);
            check("done_idle", busy, 1'b0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int op;
    reset = 1'b0; IR = '0; MemData = '0; ALU = '0; MDR = '0;
    AccSrc = '0; AccWrite = 1'b0; SpOp = 2'b00; mem_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    check_reset_state("init");
    mon_en = 1'b1;

    // Immediate loads build 1234, then sign-extended 80
    acc_load(3'd0, 8'h12);
    acc_load(3'd6, 8'h34);
    check("t2_acc", AccOutput, 16'h1234);
    imm_check(8'h80);
    check("t2_se_const", {SE, SELeft, ZE}, {16'hFF80, 16'hFF00, 16'h0080});
    acc_load(3'd3, 8'h80);
    check("t2_acc_se", AccOutput, 16'hFF80);
    acc_load(3'd0, 8'h12);
    acc_load(3'd6, 8'h34);

    // Push with two stalled cycles and a same-cycle AccWrite, then an immediate pop
    do_push(2, 1'b1);
    check("t3_sp", SpOutput, 16'hFFFC);
    do_pop(0, 16'hABCD);
    tick();
    check("t4_acc", AccOutput, 16'hABCD);
    check("t4_sp", SpOutput, 16'hFFFE);

    // Pop from the empty-stack top
    do_pop(1, 16'h5A5A);
    tick();
    check("t5_sp", SpOutput, GUARD ? 16'hFFFE : 16'h0000);
    check("t5_unf", stack_unf, GUARD);
    sp_load(16'hFFFE, 1'b0);

    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1: acc_load(3'($urandom), 8'($urandom));
        2:    imm_check(8'($urandom));
        3:    sp_load(($urandom_range(0, 3) == 0) ? 16'($urandom)
                      : 16'(16'hFFFE - 16'(2 * $urandom_range(0, 130))), 1'($urandom));
        4, 5, 6: do_push($urandom_range(0, 3), 1'($urandom));
        default: do_pop($urandom_range(0, 3), 16'($urandom));
      endcase
    end

    // Reset for one edge mid-run from idle
    repeat (2) tick();
    check("q_req_drained", q_req.size(), 0);
    check("q_done_drained", q_done.size(), 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_reset_state("mid");

    // Reset while a push waits on mem_ready
    mon_en = 1'b0;
    noise();
    SpOp = 2'b01;
    tick();
    SpOp = 2'b00;
    tick();
    check("t6_wr_pending", {busy, mem_wr}, 2'b11);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_reset_state("t6");
    tick();
    check("t6_no_done", {done, mem_wr, busy}, 3'b000);
    check("t6_sp", SpOutput, 16'hFFFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
